// File: rtl/sha_message_feeder.sv
// Feeds padded 512-bit SHA-256 second-chunk messages, one nonce per clock, into the schedule stage.
// Optional build macro FEEDER_NONCE_BYTESWAP_EN places the nonce byte-reversed in W[3].
module sha_message_feeder #(
  parameter int unsigned WORDBITS   = 32,
  parameter int unsigned MSGWORDS   = 16,
  parameter int unsigned MSGLENBITS = 640
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [3*WORDBITS-1:0]         tail_in,
  input  logic [WORDBITS-1:0]           nonce_first,
  input  logic [WORDBITS-1:0]           nonce_last,
  input  logic                          hold,
  input  logic                          abort,
  output logic [MSGWORDS*WORDBITS-1:0]  W_out,
  output logic                          W_valid,
  output logic                          W_last,
  output logic [WORDBITS-1:0]           nonce_out,
  output logic                          busy
);

  localparam int unsigned MSGBITS  = MSGWORDS * WORDBITS;
  localparam int unsigned TAILBITS = 3 * WORDBITS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [TAILBITS-1:0]  tail_q;
  logic [WORDBITS-1:0]  n;
  logic [WORDBITS-1:0]  last;

  // Nonce as it appears inside the message word.
  function automatic logic [WORDBITS-1:0] nonce_word(input logic [WORDBITS-1:0] v);
`ifdef FEEDER_NONCE_BYTESWAP_EN
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
    return v;
`endif
  endfunction

  // Padded second chunk: tail, nonce, pad bit, zeros, total length.
  function automatic logic [MSGBITS-1:0] build_msg(input logic [TAILBITS-1:0] t,
                                                   input logic [WORDBITS-1:0] v);
    logic [MSGBITS-1:0] m;
    m = '0;
    m[TAILBITS-1:0]                   = t;
    m[3*WORDBITS +: WORDBITS]         = nonce_word(v);
    m[4*WORDBITS +: WORDBITS]         = {1'b1, {(WORDBITS-1){1'b0}}};
    m[(MSGWORDS-1)*WORDBITS +: WORDBITS] = WORDBITS'(MSGLENBITS);
    return m;
  endfunction

  assign load_ready = (state == IDLE) && rst_n;
  assign busy       = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      W_out     <= '0;
      nonce_out <= '0;
      W_valid   <= 1'b0;
      W_last    <= 1'b0;
    end else begin
      W_valid <= 1'b0;
      W_last  <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (load_valid) begin
              tail_q <= tail_in;
              n      <= nonce_first;
              last   <= nonce_last;
              state  <= RUN;
            end
          end
          RUN: begin
            if (!hold) begin
              W_out     <= build_msg(tail_q, n);
              W_valid   <= 1'b1;
              nonce_out <= n;
              W_last    <= (n == last);
              if (n == last) begin
                state <= IDLE;
              end else begin
                n <= n + WORDBITS'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha_message_feeder.sv
// Directed bench for sha_message_feeder: job table plus hand sequences for abort and reset.
module tb_sha_message_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [95:0]  tail_in;
  logic [31:0]  nonce_first;
  logic [31:0]  nonce_last;
  logic         hold;
  logic         abort;
  logic [511:0] W_out;
  logic         W_valid;
  logic         W_last;
  logic [31:0]  nonce_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  sha_message_feeder dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .tail_in(tail_in), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .hold(hold), .abort(abort), .W_out(W_out), .W_valid(W_valid), .W_last(W_last),
    .nonce_out(nonce_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] tail;
    logic [31:0] first;
    logic [31:0] last;
    int          count;
    logic [31:0] hold_mask;
    logic [31:0] w3_first;
  } job_t;

  localparam logic [95:0] TAIL_A = {32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [95:0] TAIL_B = {32'hCAFEF00D, 32'hDEADBEEF, 32'h01234567};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_w3(input logic [31:0] v);
`ifdef FEEDER_NONCE_BYTESWAP_EN
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
    return v;
`endif
  endfunction

  function automatic logic [511:0] exp_msg(input logic [95:0] t, input logic [31:0] v);
    logic [511:0] m;
    m = '0;
    m[95:0]    = t;
    m[127:96]  = exp_w3(v);
    m[159:128] = 32'h80000000;
    m[511:480] = 32'h00000280;
    return m;
  endfunction

  task automatic chk_msg(input string name, input logic [95:0] t, input logic [31:0] v);
    logic [511:0] e;
    e = exp_msg(t, v);
    checks++;
    if (W_out !== e) begin
      errors++;
      for (int i = 0; i < 16; i++)
        if (W_out[32*i +: 32] !== e[32*i +: 32])
          $display("FAIL %s word %0d: got %h expected %h", name, i, W_out[32*i +: 32], e[32*i +: 32]);
    end
  endtask

  // Load a job and follow every RUN edge, honouring the hold mask.
  task automatic run_job(input job_t j, input string name);
    int got;
    int edge_i;
    logic [31:0] exp_n;
    chk({name, " ready"}, 32'(load_ready), 32'd1);
    tail_in = j.tail; nonce_first = j.first; nonce_last = j.last; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk({name, " busy"}, 32'(busy), 32'd1);
    got = 0;
    edge_i = 0;
    while (got < j.count && edge_i < j.count + 32) begin
      hold = (edge_i < 32) ? j.hold_mask[edge_i] : 1'b0;
      step();
      if (hold) begin
        chk({name, " hold valid"}, 32'(W_valid), 32'd0);
        chk({name, " hold last"}, 32'(W_last), 32'd0);
        chk({name, " hold nonce"}, nonce_out, j.first + 32'(got - 1));
        chk_msg({name, " hold msg"}, j.tail, j.first + 32'(got - 1));
      end else begin
        exp_n = j.first + 32'(got);
        chk({name, " valid"}, 32'(W_valid), 32'd1);
        chk({name, " nonce"}, nonce_out, exp_n);
        chk({name, " last"}, 32'(W_last), 32'(got == j.count - 1));
        chk({name, " ready w/ last"}, 32'(load_ready), 32'(got == j.count - 1));
        chk_msg({name, " msg"}, j.tail, exp_n);
        if (got == 0) chk({name, " W3"}, W_out[127:96], j.w3_first);
        got++;
      end
      edge_i++;
    end
    hold = 1'b0;
    if (got < j.count) chk({name, " timeout"}, 32'(got), 32'(j.count));
    step();
    chk({name, " idle valid"}, 32'(W_valid), 32'd0);
    chk({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  job_t jobs[4];
  job_t single;

  initial begin
`ifdef FEEDER_NONCE_BYTESWAP_EN
    jobs[0] = '{TAIL_A, 32'd5, 32'd8, 4, 32'h0, 32'h05000000};
    jobs[1] = '{TAIL_B, 32'hFFFFFFFE, 32'd1, 4, 32'h0, 32'hFEFFFFFF};
    jobs[2] = '{TAIL_A, 32'd0, 32'd3, 4, 32'h6, 32'h00000000};
    jobs[3] = '{TAIL_B, 32'h12345678, 32'h12345678, 1, 32'h0, 32'h78563412};
    single  = '{TAIL_A, 32'd100, 32'd100, 1, 32'h0, 32'h64000000};
`else
    jobs[0] = '{TAIL_A, 32'd5, 32'd8, 4, 32'h0, 32'h00000005};
    jobs[1] = '{TAIL_B, 32'hFFFFFFFE, 32'd1, 4, 32'h0, 32'hFFFFFFFE};
    jobs[2] = '{TAIL_A, 32'd0, 32'd3, 4, 32'h6, 32'h00000000};
    jobs[3] = '{TAIL_B, 32'h12345678, 32'h12345678, 1, 32'h0, 32'h12345678};
    single  = '{TAIL_A, 32'd100, 32'd100, 1, 32'h0, 32'h00000064};
`endif

    rst_n = 1'b0; load_valid = 1'b0; tail_in = '0; nonce_first = '0; nonce_last = '0;
    hold = 1'b0; abort = 1'b0;
    step(); step();
    chk("reset ready", 32'(load_ready), 32'd0);
    chk("reset valid", 32'(W_valid), 32'd0);
    chk("reset last", 32'(W_last), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset nonce", nonce_out, 32'd0);
    chk("reset W3", W_out[127:96], 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready after reset", 32'(load_ready), 32'd1);

    for (int k = 0; k < 4; k++) run_job(jobs[k], $sformatf("job%0d", k));

    // Abort outranks a load offered in IDLE.
    tail_in = TAIL_A; nonce_first = 32'd0; nonce_last = 32'd9;
    load_valid = 1'b1; abort = 1'b1;
    step();
    load_valid = 1'b0; abort = 1'b0;
    chk("abort beats load", 32'(busy), 32'd0);

    // Abort after the second message of 0..9.
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    chk("abort seq n0", nonce_out, 32'd0);
    step();
    chk("abort seq n1", nonce_out, 32'd1);
    chk("abort seq v1", 32'(W_valid), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort valid", 32'(W_valid), 32'd0);
    chk("abort last", 32'(W_last), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("after abort valid", 32'(W_valid), 32'd0);
      chk("after abort last", 32'(W_last), 32'd0);
    end
    run_job(single, "single100");

    // Reset in the middle of a job.
    tail_in = TAIL_B; nonce_first = 32'd50; nonce_last = 32'd60;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step(); step();
    chk("pre-reset nonce", nonce_out, 32'd51);
    rst_n = 1'b0;
    step();
    chk("midreset ready", 32'(load_ready), 32'd0);
    chk("midreset valid", 32'(W_valid), 32'd0);
    chk("midreset last", 32'(W_last), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset nonce", nonce_out, 32'd0);
    chk("midreset W15", W_out[511:480], 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready after midreset", 32'(load_ready), 32'd1);
    step();
    chk("no resume valid", 32'(W_valid), 32'd0);
    run_job(jobs[0], "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
